// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - PLL-lock gated reset controller releasing domains in order, domain 0 first
// Optional macro RESET_SEQUENCER_EVENT_COUNT_EN adds the saturating reset_events counter output.
module reset_sequencer #(
    parameter int NUM_DOMAINS  = 4,
    parameter int HOLD_CYCLES  = 16,
    parameter int STEP_CYCLES  = 8,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   pll_locked,
    input  logic                   soft_reset_req,
    output logic [NUM_DOMAINS-1:0] reset_out,
    output logic                   ready,
    output logic                   fault,
    output logic [2:0]             state
`ifdef RESET_SEQUENCER_EVENT_COUNT_EN
    ,
    output logic [7:0]             reset_events
`endif
);
    localparam int MAX_HS  = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int MAX_ALL = (MAX_HS > LOCK_TIMEOUT) ? MAX_HS : LOCK_TIMEOUT;
    localparam int CW      = $clog2(MAX_ALL) + 1;

    localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STEP_LAST    = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_HOLD      = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_DOMAINS-1:0] ro_q, ro_d, ro_shift;
    logic                   ready_q, ready_d;
    logic                   fault_q, fault_d;
    logic                   lock_meta, lock_s;
    logic                   abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
            ro_q    <= '1;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ro_q    <= ro_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
        end
    end

    // Shifting left with zero fill clears the next domain in ascending order.
    assign ro_shift = ro_q << 1;
    assign abort    = !lock_s || soft_reset_req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ro_d    = ro_q;
        ready_d = ready_q;
        fault_d = fault_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                ro_d    = '1;
                ready_d = 1'b0;
                fault_d = 1'b0;
                if (lock_s) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else if (soft_reset_req) begin
                    cnt_d = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD, ST_RELEASE: begin
                if (abort) begin
                    state_d = ST_WAIT_LOCK;
                    ro_d    = '1;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                end else if ((state_q == ST_HOLD && cnt_q == HOLD_LAST) ||
                             (state_q == ST_RELEASE && cnt_q == STEP_LAST)) begin
                    ro_d  = ro_shift;
                    cnt_d = '0;
                    if (ro_shift == '0) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_WAIT_LOCK;
                    ro_d    = '1;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_FAULT: begin
                ro_d    = '1;
                ready_d = 1'b0;
                fault_d = 1'b1;
                // Lock arriving late is not trusted; only software can retry.
                if (soft_reset_req) begin
                    state_d = ST_WAIT_LOCK;
                    fault_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                ro_d    = '1;
                ready_d = 1'b0;
                fault_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign reset_out = ro_q;
    assign ready     = ready_q;
    assign fault     = fault_q;
    assign state     = state_q;

`ifdef RESET_SEQUENCER_EVENT_COUNT_EN
    logic [7:0] events_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            events_q <= 8'd0;
        end else if (state_d == ST_WAIT_LOCK && state_q != ST_WAIT_LOCK && events_q != 8'hff) begin
            events_q <= events_q + 8'd1;
        end
    end

    assign reset_events = events_q;
`endif

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Central reset controller for the FPGA application.
- Waits for PLL lock, holds all downstream reset domains for a minimum time, then releases them one by one in a fixed order (domain 0 first).
- Re-asserts every domain on lock loss or on a software reset request.
- Flags a fault if lock never arrives. Its outputs drive the per-domain reset synchronizers.

Parameters:
NUM_DOMAINS, 4, number of reset domains sequenced (1..16)
HOLD_CYCLES, 16, cycles all domains stay asserted after lock is seen (>=1)
STEP_CYCLES, 8, cycles between successive domain releases (>=1)
LOCK_TIMEOUT, 1024, cycles in WAIT_LOCK without lock before FAULT (>=2)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
pll_locked  input  1  PLL lock, asynchronous to clk
soft_reset_req  input  1  single-cycle request in clk domain, restarts the sequence
reset_out  output  NUM_DOMAINS  per-domain reset, active-high (1 = held in reset)
ready  output  1  1 while all domains are released (state RUN)
fault  output  1  1 while in FAULT
state  output  3  current state code for debug

Behaviour:
- Interface: one clock, clk. Reset reset_n is asynchronous and active-low; these are fixed.
- reset_n=0, asynchronously: reset_out all ones, ready=0, fault=0, state=WAIT_LOCK, all counters 0, synchronizer flops 0.
- pll_locked passes through a 2-flop synchronizer; lock_s is the second flop. The synchronizer is reset to 0.
- All outputs are registered. No combinational path from inputs to outputs.
- States and codes: WAIT_LOCK=0, HOLD=1, RELEASE=2, RUN=3, FAULT=4.
- WAIT_LOCK:
  - reset_out all ones.
  - Counter increments each cycle while lock_s=0.
  - lock_s=1 -> HOLD, counter cleared.
  - Counter reaches LOCK_TIMEOUT-1 with lock_s=0 -> FAULT.
  - soft_reset_req clears the counter.
- HOLD:
  - Counts HOLD_CYCLES cycles.
  - On the last cycle -> RELEASE; reset_out[0] clears on that same edge.
- RELEASE:
  - reset_out[k] clears STEP_CYCLES edges after reset_out[k-1]. Released bits stay 0.
  - The edge clearing reset_out[NUM_DOMAINS-1] also sets ready=1 and enters RUN.
  - NUM_DOMAINS=1: HOLD goes straight to RUN, and ready rises with reset_out[0] clearing.
- Timing from the first clk edge sampling pll_locked=1:
  - reset_out[0] clears at edge HOLD_CYCLES+3.
  - reset_out[k] clears at edge HOLD_CYCLES+3+k*STEP_CYCLES.
- RUN: steady state; ready=1, reset_out all zeros.
- FAULT:
  - reset_out all ones, fault=1, ready=0.
  - lock_s rising alone does NOT exit.
  - soft_reset_req -> WAIT_LOCK with fault cleared and counter cleared.
- Abort from HOLD, RELEASE or RUN:
  - Trigger is lock_s=0 or soft_reset_req=1.
  - On the next edge: reset_out all ones, ready=0, go to WAIT_LOCK, counters cleared.
  - If both triggers occur in the same cycle, the result is identical.
  - A soft request with lock still present re-enters HOLD one cycle later, giving a full re-sequence.
- Glitch rule: a lock drop shorter than one clk period may be missed. Any drop seen on lock_s aborts.
- reset_n asserted mid-sequence: immediate return to the reset values above.
- Counter width: clog2 of the largest of HOLD_CYCLES, STEP_CYCLES, LOCK_TIMEOUT, plus 1. No wrap is possible.

Optional Feature:
- Macro: RESET_SEQUENCER_EVENT_COUNT_EN
- When defined:
  - Adds output reset_events [7:0].
  - Counts entries to WAIT_LOCK from HOLD, RELEASE, RUN or FAULT. The power-on entry is not counted.
  - Saturates at 255.
  - Cleared only by reset_n.
- When undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Bench parameters: NUM_DOMAINS=3, HOLD_CYCLES=4, STEP_CYCLES=2, LOCK_TIMEOUT=20.
- Power-up: reset_n released, pll_locked=1 from edge 0 -> reset_out goes 111 until edge 7, then 110 at edge 7, 100 at edge 9, 000 with ready=1 and state=3 at edge 11.
- Timeout: pll_locked held 0 -> FAULT at edge 20 with fault=1 and reset_out=111. Later pll_locked=1 -> stays in FAULT. soft_reset_req pulse -> fault=0, then the full sequence runs.
- Lock loss in RELEASE: pll_locked drops 3 edges after reset_out[0] clears -> reset_out=111 and ready=0 within 3 edges (2 sync + 1). Lock restored -> sequence restarts with the full HOLD period.
- Soft reset in RUN: pulse soft_reset_req with lock stable -> edge+1: reset_out=111 and state=0; edge+2: state=1; reset_out[0] clears 4 edges later.
- Async reset mid-HOLD: reset_n=0 between edges -> reset_out=111, state=0, ready=0 immediately, without waiting for a clock edge.
- With RESET_SEQUENCER_EVENT_COUNT_EN defined: 300 soft_reset_req pulses spaced 12 cycles apart -> reset_events=255.
